// File: rtl/gcn_mem_pkg.sv
// gcn_mem_pkg: shared types, constants and sizing helpers for the GCN
// memory responder (gcn_mem_server) and its load controller.
//   mem_state_t  : load/serve FSM states
//   FEATURE_BASE : first read_address of the feature table
//   w_n/f_n/c_n  : word counts of the weight, feature and COO tables
//   idx_w/max3   : index-width helpers
package gcn_mem_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, LOAD_C, SERVE} mem_state_t;

  localparam int unsigned FEATURE_BASE    = 512;
  localparam int unsigned COO_NUM_OF_ROWS = 2;

  localparam int unsigned DEF_FEATURE_COLS    = 96;
  localparam int unsigned DEF_WEIGHT_ROWS     = 96;
  localparam int unsigned DEF_FEATURE_ROWS    = 6;
  localparam int unsigned DEF_WEIGHT_COLS     = 3;
  localparam int unsigned DEF_FEATURE_WIDTH   = 5;
  localparam int unsigned DEF_WEIGHT_WIDTH    = 5;
  localparam int unsigned DEF_ADDRESS_WIDTH   = 13;
  localparam int unsigned DEF_COO_NUM_OF_COLS = 6;

  // One row as presented to the GCN at the default geometry.
  typedef logic [0:DEF_WEIGHT_ROWS-1][DEF_WEIGHT_WIDTH-1:0] gcn_row_t;

  function automatic int unsigned w_n(input int unsigned weight_cols,
                                      input int unsigned weight_rows);
    return weight_cols * weight_rows;
  endfunction

  function automatic int unsigned f_n(input int unsigned feature_rows,
                                      input int unsigned feature_cols);
    return feature_rows * feature_cols;
  endfunction

  function automatic int unsigned c_n(input int unsigned coo_cols);
    return COO_NUM_OF_ROWS * coo_cols;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gcn_load_ctrl.sv
// gcn_load_ctrl: serial load sequencer for the GCN memory responder.
// Walks weight table, feature table, then COO table (row-major, element 0
// first), accepting one word per cycle when load_valid & load_ready.
// Ports:
//   clk, reset          clock, async active-high reset
//   load_start          begin a load (honoured only in IDLE or SERVE)
//   load_valid          a word is presented this cycle
//   load_ready, loaded  registered status outputs
//   wr_en               write strobe for the table selected by tbl_sel
//   tbl_sel             current FSM state (doubles as table select)
//   wr_row, wr_col      row / element position of the word being written
module gcn_load_ctrl
  import gcn_mem_pkg::*;
#(
  parameter int unsigned WEIGHT_ROWS     = DEF_WEIGHT_ROWS,
  parameter int unsigned WEIGHT_COLS     = DEF_WEIGHT_COLS,
  parameter int unsigned FEATURE_ROWS    = DEF_FEATURE_ROWS,
  parameter int unsigned FEATURE_COLS    = DEF_FEATURE_COLS,
  parameter int unsigned COO_NUM_OF_COLS = DEF_COO_NUM_OF_COLS,
  parameter int unsigned ROW_W           = 3,
  parameter int unsigned COL_W           = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             loaded,
  output logic             wr_en,
  output mem_state_t       tbl_sel,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col
);

  localparam int unsigned WORD_W = idx_w(max3(w_n(WEIGHT_COLS, WEIGHT_ROWS),
                                              f_n(FEATURE_ROWS, FEATURE_COLS),
                                              c_n(COO_NUM_OF_COLS)));

  logic [WORD_W-1:0] word_cnt;
  logic [WORD_W-1:0] last_word;
  logic [COL_W-1:0]  last_col;
  mem_state_t        next_table;

  assign wr_en = load_valid & load_ready;

  always_comb begin
    last_word  = '0;
    last_col   = '0;
    next_table = IDLE;
    case (tbl_sel)
      LOAD_W: begin
        last_word  = WORD_W'(w_n(WEIGHT_COLS, WEIGHT_ROWS) - 1);
        last_col   = COL_W'(WEIGHT_ROWS - 1);
        next_table = LOAD_F;
      end
      LOAD_F: begin
        last_word  = WORD_W'(f_n(FEATURE_ROWS, FEATURE_COLS) - 1);
        last_col   = COL_W'(FEATURE_COLS - 1);
        next_table = LOAD_C;
      end
      LOAD_C: begin
        last_word  = WORD_W'(c_n(COO_NUM_OF_COLS) - 1);
        last_col   = COL_W'(COO_NUM_OF_COLS - 1);
        next_table = SERVE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_sel    <= IDLE;
      word_cnt   <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
      load_ready <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      case (tbl_sel)
        IDLE, SERVE: begin
          if (load_start) begin
            tbl_sel    <= LOAD_W;
            word_cnt   <= '0;
            wr_row     <= '0;
            wr_col     <= '0;
            load_ready <= 1'b1;
            loaded     <= 1'b0;
          end
        end
        LOAD_W, LOAD_F, LOAD_C: begin
          if (wr_en) begin
            if (word_cnt == last_word) begin
              // Final word of this table: move on in the accepting cycle.
              tbl_sel  <= next_table;
              word_cnt <= '0;
              wr_row   <= '0;
              wr_col   <= '0;
              if (tbl_sel == LOAD_C) begin
                load_ready <= 1'b0;
                loaded     <= 1'b1;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
              if (wr_col == last_col) begin
                wr_col <= '0;
                wr_row <= wr_row + 1'b1;
              end else begin
                wr_col <= wr_col + 1'b1;
              end
            end
          end
        end
        default: begin
          tbl_sel    <= IDLE;
          load_ready <= 1'b0;
          loaded     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gcn_mem_server.sv
// gcn_mem_server: synthesizable memory responder for the GCN read port.
// Holds weight, feature and COO tables loaded serially after reset, and
// serves whole rows (read_address/enable_read -> data_in) and COO column
// pairs (coo_address -> coo_in). Read-out registers update on the falling
// clock edge so the GCN can sample them on the following rising edge.
// Ports:
//   clk, reset                 clock, async active-high reset
//   load_start/valid/data      serial load interface; load_ready, loaded status
//   enable_read, read_address  row read request (weights at 0.., features at 512..)
//   data_in                    returned row (zeros for unmapped addresses)
//   coo_address, coo_in        COO column index and its {src,dst}
//   range_err                  sticky out-of-range flag
// Build option: GCN_MEM_RANGE_CHECK_EN enables range_err; otherwise it is 0.
module gcn_mem_server
  import gcn_mem_pkg::*;
#(
  parameter int unsigned FEATURE_COLS    = DEF_FEATURE_COLS,
  parameter int unsigned WEIGHT_ROWS     = DEF_WEIGHT_ROWS,
  parameter int unsigned FEATURE_ROWS    = DEF_FEATURE_ROWS,
  parameter int unsigned WEIGHT_COLS     = DEF_WEIGHT_COLS,
  parameter int unsigned FEATURE_WIDTH   = DEF_FEATURE_WIDTH,
  parameter int unsigned WEIGHT_WIDTH    = DEF_WEIGHT_WIDTH,
  parameter int unsigned ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
  parameter int unsigned COO_NUM_OF_COLS = DEF_COO_NUM_OF_COLS,
  parameter int unsigned COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load_start,
  input  logic                                    load_valid,
  input  logic [WEIGHT_WIDTH-1:0]                 load_data,
  output logic                                    load_ready,
  output logic                                    loaded,
  input  logic                                    enable_read,
  input  logic [ADDRESS_WIDTH-1:0]                read_address,
  output logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] data_in,
  input  logic [COO_BW-1:0]                       coo_address,
  output logic [0:1][COO_BW-1:0]                  coo_in,
  output logic                                    range_err
);

  localparam int unsigned ROW_W = idx_w(max3(WEIGHT_COLS, FEATURE_ROWS, COO_NUM_OF_ROWS));
  localparam int unsigned COL_W = idx_w(max3(WEIGHT_ROWS, FEATURE_COLS, COO_NUM_OF_COLS));
  localparam int unsigned WI_W  = idx_w(WEIGHT_COLS);
  localparam int unsigned FI_W  = idx_w(FEATURE_ROWS);
  localparam int unsigned CI_W  = idx_w(COO_NUM_OF_COLS);

  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]   weight_mem  [WEIGHT_COLS];
  logic [0:FEATURE_COLS-1][FEATURE_WIDTH-1:0] feature_mem [FEATURE_ROWS];
  logic [COO_BW-1:0]                          coo_mem     [COO_NUM_OF_ROWS][COO_NUM_OF_COLS];

  logic             wr_en;
  mem_state_t       tbl_sel;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;

  logic                                   w_hit;
  logic                                   f_hit;
  logic                                   coo_hit;
  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] row_sel;
  logic [0:1][COO_BW-1:0]                 pair_sel;

  gcn_load_ctrl #(
    .WEIGHT_ROWS    (WEIGHT_ROWS),
    .WEIGHT_COLS    (WEIGHT_COLS),
    .FEATURE_ROWS   (FEATURE_ROWS),
    .FEATURE_COLS   (FEATURE_COLS),
    .COO_NUM_OF_COLS(COO_NUM_OF_COLS),
    .ROW_W          (ROW_W),
    .COL_W          (COL_W)
  ) u_load_ctrl (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .loaded    (loaded),
    .wr_en     (wr_en),
    .tbl_sel   (tbl_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col)
  );

  // Table storage is deliberately not reset; a load rewrites every word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (tbl_sel)
        LOAD_W:  weight_mem[wr_row[WI_W-1:0]][wr_col] <= load_data;
        LOAD_F:  feature_mem[wr_row[FI_W-1:0]][wr_col] <= load_data;
        LOAD_C:  coo_mem[wr_row[0]][wr_col[CI_W-1:0]] <= load_data[COO_BW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_hit   = read_address < ADDRESS_WIDTH'(WEIGHT_COLS);
    f_hit   = (read_address >= ADDRESS_WIDTH'(FEATURE_BASE)) &&
              (read_address <  ADDRESS_WIDTH'(FEATURE_BASE + FEATURE_ROWS));
    // Extra bit keeps the compare correct when COO_NUM_OF_COLS == 2**COO_BW.
    coo_hit = {1'b0, coo_address} < (COO_BW + 1)'(COO_NUM_OF_COLS);
    row_sel = '0;
    if (w_hit) begin
      row_sel = weight_mem[read_address[WI_W-1:0]];
    end else if (f_hit) begin
      row_sel = feature_mem[FI_W'(read_address - ADDRESS_WIDTH'(FEATURE_BASE))];
    end
    pair_sel = '0;
    if (coo_hit) begin
      pair_sel = {coo_mem[0][coo_address], coo_mem[1][coo_address]};
    end
  end

  // Half-cycle read latency: launch on the falling edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      data_in <= '0;
      coo_in  <= '0;
    end else if (loaded) begin
      if (enable_read) begin
        data_in <= row_sel;
      end
      coo_in <= pair_sel;
    end
  end

`ifdef GCN_MEM_RANGE_CHECK_EN
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      range_err <= 1'b0;
    end else if (loaded && ((enable_read && !(w_hit || f_hit)) || !coo_hit)) begin
      range_err <= 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcn_mem_server.sv
// tb_gcn_mem_server: randomized self-checking bench for gcn_mem_server.
// A table-level model records every accepted load word by its position in
// the load stream and predicts the falling-edge read-out each cycle.
module tb_gcn_mem_server;

  localparam int FC = 96, WR = 96, FR = 6, WC = 3, W = 5, AW = 13;
  localparam int CN = 6, CB = 3;
  localparam int WN = WC * WR, FN = FR * FC, TOT = WN + FN + 2 * CN;
`ifdef GCN_MEM_RANGE_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef logic [0:WR-1][W-1:0] row_t;
  typedef logic [0:1][CB-1:0]   pair_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic          load_ready;
  logic          loaded;
  logic          enable_read = 1'b0;
  logic [AW-1:0] read_address = '0;
  row_t          data_in;
  logic [CB-1:0] coo_address = '0;
  pair_t         coo_in;
  logic          range_err;

  gcn_mem_server #(
    .FEATURE_COLS(FC), .WEIGHT_ROWS(WR), .FEATURE_ROWS(FR), .WEIGHT_COLS(WC),
    .FEATURE_WIDTH(W), .WEIGHT_WIDTH(W), .ADDRESS_WIDTH(AW),
    .COO_NUM_OF_COLS(CN), .COO_BW(CB)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .loaded(loaded),
    .enable_read(enable_read), .read_address(read_address), .data_in(data_in),
    .coo_address(coo_address), .coo_in(coo_in), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]  mw [WC][WR];
  logic [W-1:0]  mf [FR][FC];
  logic [CB-1:0] mc [2][CN];
  bit    m_loading = 1'b0;
  bit    m_loaded = 1'b0;
  int    m_cnt = 0;
  row_t  e_data = '0;
  pair_t e_coo = '0;
  logic  e_err = 1'b0;

  function automatic row_t row_of(input int a);
    row_t r;
    r = '0;
    if (a < WC) begin
      for (int e = 0; e < WR; e++) r[e] = mw[a][e];
    end else if (a >= 512 && a < 512 + FR) begin
      for (int e = 0; e < FC; e++) r[e] = mf[a - 512][e];
    end
    return r;
  endfunction

  function automatic pair_t pair_of(input int c);
    pair_t p;
    p = '0;
    if (c < CN) p = {mc[0][c], mc[1][c]};
    return p;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_loading = 1'b0; m_loaded = 1'b0; m_cnt = 0;
    end else if (load_start && !m_loading) begin
      m_loading = 1'b1; m_loaded = 1'b0; m_cnt = 0;
    end else if (m_loading && load_valid) begin
      if (m_cnt < WN) mw[m_cnt / WR][m_cnt % WR] = load_data;
      else if (m_cnt < WN + FN) mf[(m_cnt - WN) / FC][(m_cnt - WN) % FC] = load_data;
      else mc[(m_cnt - WN - FN) / CN][(m_cnt - WN - FN) % CN] = load_data[CB-1:0];
      m_cnt++;
      if (m_cnt == TOT) begin m_loading = 1'b0; m_loaded = 1'b1; end
    end
  end

  initial forever begin
    @(negedge clk or posedge reset);
    if (reset) begin
      e_data = '0; e_coo = '0; e_err = 1'b0;
    end else if (m_loaded) begin
      int a;
      bit oob;
      a = int'(read_address);
      oob = !(a < WC || (a >= 512 && a < 512 + FR));
      if (enable_read) e_data = row_of(a);
      e_coo = pair_of(int'(coo_address));
      if (ERR_EN && ((enable_read && oob) || int'(coo_address) >= CN)) e_err = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (cmp_en) begin
      chk("loaded",     512'(loaded),     512'(m_loaded));
      chk("load_ready", 512'(load_ready), 512'(m_loading));
      chk("data_in",    512'(data_in),    512'(e_data));
      chk("coo_in",     512'(coo_in),     512'(e_coo));
      chk("range_err",  512'(range_err),  512'(e_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] pattern(input int k);
    return W'((k * 7 + 3) % 32);
  endfunction

  // mode 0: valid every cycle, pattern data; 1: valid alternating, pattern
  // data; 2: random valid/data with stray load_start pulses.
  task automatic load_all(input int mode, input int abort_after, output int n);
    int widx;
    n = 0;
    widx = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    while (n < 4000) begin
      case (mode)
        0:       load_valid = 1'b1;
        1:       load_valid = (n % 2 == 0);
        default: load_valid = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) load_start = ($urandom_range(0, 40) == 0);
      load_data = (mode == 2) ? W'($urandom) : pattern(widx);
      tick();
      n++;
      if (load_valid) widx++;
      if (loaded) break;
      if (abort_after != 0 && n >= abort_after) break;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic rand_reads(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      int pick;
      enable_read = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2: read_address = AW'($urandom_range(0, WC - 1));
        3:       read_address = AW'(WC);
        4, 5, 6: read_address = AW'(512 + $urandom_range(0, FR - 1));
        7:       read_address = AW'(511);
        8:       read_address = AW'(512 + FR);
        default: read_address = AW'($urandom_range(0, 8191));
      endcase
      coo_address = CB'($urandom_range(0, 7));
      tick();
    end
    enable_read = 1'b0;
    coo_address = '0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst_data", 512'(data_in), 512'(0));
    chk("rst_loaded", 512'(loaded), 512'(0));

    // Full load, valid every cycle: loaded on the 876th accepting edge.
    load_all(0, 0, n);
    chk("latency_valid1", 512'(n), 512'(TOT));

    // Hand-derived values from the load pattern (k*7+3)%32.
    coo_address = '0;
    read_address = AW'(2); enable_read = 1'b0;
    tick();
    chk("hold_no_enable", 512'(data_in), 512'(0));
    enable_read = 1'b1;
    tick();
    chk("w2_e0", 512'(data_in[0]), 512'(3));
    chk("coo0_src", 512'(coo_in[0]), 512'(3));
    chk("coo0_dst", 512'(coo_in[1]), 512'(5));
    read_address = AW'(517);
    tick();
    chk("f5_e5", 512'(data_in[5]), 512'(6));
    chk("err_clear", 512'(range_err), 512'(0));
    read_address = AW'(3);
    tick();
    chk("oob3_data", 512'(data_in), 512'(0));
    chk("oob3_err", 512'(range_err), 512'(ERR_EN));
    read_address = AW'(517);
    tick();
    read_address = AW'(600);
    tick();
    chk("oob600_data", 512'(data_in), 512'(0));
    enable_read = 1'b0;

    for (int c = 0; c < 8; c++) begin
      coo_address = CB'(c);
      tick();
    end
    rand_reads(200);

    // Reload from SERVE with valid toggling: 876th accept on edge 1751.
    load_all(1, 0, n);
    chk("latency_toggle", 512'(n), 512'(2 * TOT - 1));
    rand_reads(150);

    // Random-valid reload with stray load_start pulses mid-load.
    load_all(2, 0, n);
    chk("rand_load_done", 512'(loaded), 512'(1));
    rand_reads(150);

    // Reset during the feature phase; nothing served until a full reload.
    load_all(0, 400, n);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("midrst_loaded", 512'(loaded), 512'(0));
    chk("midrst_ready", 512'(load_ready), 512'(0));
    rand_reads(40);
    chk("midrst_hold", 512'(data_in), 512'(0));
    load_all(2, 0, n);
    chk("reload_done", 512'(loaded), 512'(1));
    rand_reads(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
